wb_regfile: RTL and testbench

Write-back stage and architectural register file of the ArqMIPS32 pipeline; consumes the MEM/WB pipeline register outputs and commits results to the 32-entry register file. Selects between the loaded memory word and the ALU result and writes the selected value to the destination register. Serves the ID stage's two read ports with same-cycle write-to-read bypass. Keeps a committed-write counter for debug.

---
 rtl/mips32_pkg.sv | 22 ++
 rtl/wb_regfile_if.sv | 32 +++
 rtl/regfile32.sv | 34 +++
 rtl/wb_regfile.sv | 79 +++++++
 tb/tb_wb_regfile.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// mips32_pkg: constants shared by the ArqMIPS32 pipeline blocks.
//   WB control bundle bit positions, register-file geometry and the
//   architectural zero register index.
package mips32_pkg;

  localparam int unsigned SIZE_DATA   = 32;
  localparam int unsigned SIZE_ADDR   = 5;
  localparam int unsigned S_WB        = 2;

  // Bit positions inside the WB control bundle {RegWrite, MemToReg}
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam logic [4:0]  REG_ZERO    = 5'd0;

  // Source of the write-back value
  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB -> write-back bus plus the ID-stage read ports.
//   master (pipeline side) drives WB, DatoLeido, direccion,
//   direccionRegistro, rs_addr, rt_addr and observes rs_data, rt_data,
//   wb_data, wb_we, commit_count.
//   slave  (wb_regfile) is the mirror image.
interface wb_regfile_if #(
  parameter int unsigned S_WB      = 2,
  parameter int unsigned SIZE_DATA = 32,
  parameter int unsigned SIZE_ADDR = 5
);
  logic [S_WB-1:0]      WB;
  logic [SIZE_DATA-1:0] DatoLeido;
  logic [SIZE_DATA-1:0] direccion;
  logic [SIZE_ADDR-1:0] direccionRegistro;
  logic [SIZE_ADDR-1:0] rs_addr;
  logic [SIZE_ADDR-1:0] rt_addr;
  logic [SIZE_DATA-1:0] rs_data;
  logic [SIZE_DATA-1:0] rt_data;
  logic [SIZE_DATA-1:0] wb_data;
  logic                 wb_we;
  logic [31:0]          commit_count;

  modport master (
    output WB, DatoLeido, direccion, direccionRegistro, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_we, commit_count
  );

  modport slave (
    input  WB, DatoLeido, direccion, direccionRegistro, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_we, commit_count
  );
endinterface

// File: rtl/regfile32.sv
// regfile32: plain storage array for the architectural register file.
//   clk, rst      : clock, synchronous active-high clear of every entry
//   we/waddr/wdata: single write port, committed on the rising edge
//   raddr_a/rdata_a, raddr_b/rdata_b: asynchronous read ports (raw
//                   contents; zero masking and bypass live in the caller)
module regfile32 #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: ArqMIPS32 write-back stage and 32-entry register file.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_regfile_if slave
//     WB {RegWrite, MemToReg}, DatoLeido, direccion, direccionRegistro in
//     rs_addr/rs_data, rt_addr/rt_data : combinational read ports with
//                                        same-cycle write bypass
//     wb_data  : selected write-back value (to forwarding unit)
//     wb_we    : effective write enable this cycle
//     commit_count : number of committed register writes, wraps at 2^32
module wb_regfile
  import mips32_pkg::*;
#(
  parameter int unsigned S_WB      = 2,
  parameter int unsigned SIZE_DATA = 32,
  parameter int unsigned SIZE_ADDR = 5
) (
  input logic        clk,
  input logic        rst,
  wb_regfile_if.slave bus
);

  logic [S_WB-1:0]      wb_ctl;
  wb_sel_e              sel;
  logic [SIZE_DATA-1:0] wb_data;
  logic                 wb_we;
  logic [SIZE_DATA-1:0] raw_a, raw_b;
  logic [SIZE_DATA-1:0] rs_data, rt_data;
  logic [31:0]          cnt_q;

  assign wb_ctl  = bus.WB;
  assign sel     = wb_sel_e'(wb_ctl[WB_MEMTOREG]);
  assign wb_data = (sel == WB_SEL_MEM) ? bus.DatoLeido : bus.direccion;

  // Gating with ~rst here keeps the bypass, the store and the counter
  // consistent during reset without extra qualification downstream.
  assign wb_we = wb_ctl[WB_REGWRITE]
               & (bus.direccionRegistro != SIZE_ADDR'(REG_ZERO))
               & ~rst;

  regfile32 #(
    .DW (SIZE_DATA),
    .AW (SIZE_ADDR)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (bus.direccionRegistro),
    .wdata   (wb_data),
    .raddr_a (bus.rs_addr),
    .rdata_a (raw_a),
    .raddr_b (bus.rt_addr),
    .rdata_b (raw_b)
  );

  always_comb begin
    rs_data = raw_a;
    rt_data = raw_b;
    if (rst || bus.rs_addr == SIZE_ADDR'(REG_ZERO))
      rs_data = '0;
    else if (wb_we && bus.rs_addr == bus.direccionRegistro)
      rs_data = wb_data;
    if (rst || bus.rt_addr == SIZE_ADDR'(REG_ZERO))
      rt_data = '0;
    else if (wb_we && bus.rt_addr == bus.direccionRegistro)
      rt_data = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        cnt_q <= '0;
    else if (wb_we) cnt_q <= cnt_q + 32'd1;
  end

  assign bus.rs_data      = rs_data;
  assign bus.rt_data      = rt_data;
  assign bus.wb_data      = wb_data;
  assign bus.wb_we        = wb_we;
  assign bus.commit_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized bench for wb_regfile, checked
// against an array-based model of the architectural register file.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.S_WB(2), .SIZE_DATA(32), .SIZE_ADDR(5)) bus ();

  wb_regfile #(.S_WB(2), .SIZE_DATA(32), .SIZE_ADDR(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt = '0;

  function automatic logic m_we();
    return bus.WB[1] && (bus.direccionRegistro != 5'd0) && !rst;
  endfunction

  function automatic logic [31:0] m_wbd();
    return bus.WB[0] ? bus.DatoLeido : bus.direccion;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (m_we() && a == bus.direccionRegistro) return m_wbd();
    return m_regs[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs already settled: compare every output with the model, take
  // one rising edge, advance the model, return on the following negedge.
  task automatic step(input string tag);
    logic        we;
    logic [31:0] d;
    logic [4:0]  a;
    logic        r;
    chk({tag, ".rs_data"}, bus.rs_data, m_read(bus.rs_addr));
    chk({tag, ".rt_data"}, bus.rt_data, m_read(bus.rt_addr));
    chk({tag, ".wb_data"}, bus.wb_data, m_wbd());
    chk({tag, ".wb_we"}, {31'd0, bus.wb_we}, {31'd0, m_we()});
    chk({tag, ".commit_count"}, bus.commit_count, m_cnt);
    we = m_we(); d = m_wbd(); a = bus.direccionRegistro; r = rst;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
    end else if (we) begin
      m_regs[a] = d;
      m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] wb, input logic [31:0] ld,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.WB = wb; bus.DatoLeido = ld; bus.direccion = alu;
    bus.direccionRegistro = rd; bus.rs_addr = rs; bus.rt_addr = rt;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 'x;
    m_cnt = 'x;
    drive(2'b00, '0, '0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);

    // 1. Reset, then every index reads 0
    rst = 1'b1;
    #1;
    chk("rst.wb_we", {31'd0, bus.wb_we}, 32'd0);
    @(posedge clk);
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(2'b00, 32'h5555_5555, 32'h6666_6666, 5'(i), 5'(i), 5'(31 - i));
      chk("reset.read_all", bus.rs_data, 32'd0);
      step("reset");
    end
    chk("reset.commit_count", bus.commit_count, 32'd0);

    // 2. ALU write-back with bypass
    drive(2'b10, 32'h0, 32'h0000_1234, 5'd8, 5'd8, 5'd0);
    chk("alu.bypass", bus.rs_data, 32'h0000_1234);
    step("alu");
    drive(2'b00, 32'h0, 32'h0, 5'd8, 5'd8, 5'd8);
    chk("alu.stored", bus.rs_data, 32'h0000_1234);
    chk("alu.count", bus.commit_count, 32'd1);
    step("alu_rd");

    // 3. Load write-back
    drive(2'b11, 32'hDEAD_BEEF, 32'h10, 5'd31, 5'd0, 5'd31);
    chk("load.wb_data", bus.wb_data, 32'hDEAD_BEEF);
    step("load");
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd31, 5'd8);
    chk("load.stored", bus.rs_data, 32'hDEAD_BEEF);
    step("load_rd");

    // 4. $zero protection
    drive(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    chk("zero.rs", bus.rs_data, 32'd0);
    chk("zero.rt", bus.rt_data, 32'd0);
    chk("zero.wb_we", {31'd0, bus.wb_we}, 32'd0);
    step("zero");
    chk("zero.count", bus.commit_count, 32'd2);

    // 5. Reset mid-operation wins over a concurrent write
    drive(2'b10, 32'h0, 32'h0000_AAAA, 5'd5, 5'd5, 5'd0);
    step("pre_rst");
    rst = 1'b1;
    drive(2'b10, 32'h0, 32'h0000_BBBB, 5'd5, 5'd5, 5'd5);
    chk("midrst.wb_we", {31'd0, bus.wb_we}, 32'd0);
    chk("midrst.rs", bus.rs_data, 32'd0);
    chk("midrst.wb_data", bus.wb_data, 32'h0000_BBBB);
    step("midrst");
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
    chk("midrst.reg5", bus.rs_data, 32'd0);
    chk("midrst.reg31", bus.rt_data, 32'd0);
    chk("midrst.count", bus.commit_count, 32'd0);
    step("post_rst");

    // 6. Back-to-back writes to one index, then counter wrap
    for (int i = 1; i <= 3; i++) begin
      drive(2'b10, 32'h0, 32'hC000_0000 + 32'(i), 5'd3, 5'd3, 5'd3);
      step("b2b");
    end
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    chk("b2b.last", bus.rs_data, 32'hC000_0003);
    chk("b2b.count", bus.commit_count, 32'd3);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    chk("wrap.preload", bus.commit_count, 32'hFFFF_FFFF);
    drive(2'b10, 32'h0, 32'h0000_0077, 5'd7, 5'd7, 5'd3);
    step("wrap");
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    chk("wrap.count", bus.commit_count, 32'd0);
    chk("wrap.reg7", bus.rs_data, 32'h0000_0077);
    step("wrap_rd");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] rd, rs, rt;
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      rt = ($urandom_range(0, 4) == 0) ? rs : 5'($urandom);
      rst = ($urandom_range(0, 60) == 0);
      drive(2'($urandom), $urandom, $urandom, rd, rs, rt);
      step("rand");
    end
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    step("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
